sfifo_param: RTL
================

Name: sfifo_param

Overview:
- Parameterised single-clock synchronous FIFO; successor to the fixed 8x8 FIFO.
- Adds configurable data width and depth, and uses all DEPTH entries through an extra pointer wrap bit.
- Adds an occupancy count, programmable almost-full/almost-empty flags, overflow/underflow error pulses and a synchronous flush.
- Used as the general-purpose elastic buffer between producer/consumer blocks in one clock domain.

Parameters:
- WIDTH, 8, data word width in bits (>=1).
- DEPTH, 8, number of storage entries; power of two, >=2.
- AF_TH, DEPTH-1, almost_full asserts when count >= AF_TH (1..DEPTH).
- AE_TH, 1, almost_empty asserts when count <= AE_TH (0..DEPTH-1).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- flush  in  1  synchronous clear of FIFO contents.
- write_e  in  1  write request.
- data_in  in  WIDTH  write data.
- read_e  in  1  read request.
- data_out  out  WIDTH  registered read data.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count >= AF_TH.
- almost_empty  out  1  count <= AE_TH.
- count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- overflow  out  1  one-cycle pulse: write rejected.
- underflow  out  1  one-cycle pulse: read rejected.

Behaviour:
- Reset (reset=0, asynchronous, takes effect immediately):
  - Write/read pointers = 0, count = 0, data_out = 0, overflow = underflow = 0.
  - Hence empty = 1, full = 0, almost_empty = 1, almost_full = (AF_TH==0 ? 1 : 0).
  - Memory contents are not reset.
  - Reset deasserting mid-operation: the FIFO restarts empty; no stale data is ever read.
- Pointers:
  - log2(DEPTH)+1 bits each; the low bits address memory and the MSB is the wrap bit.
  - Equal pointers with equal MSBs = empty.
  - Equal low bits with differing MSBs = full.
  - All DEPTH entries are usable.
  - Pointers wrap modulo 2*DEPTH naturally.
- Read acceptance: rd_ok = read_e & !empty.
- Write acceptance: wr_ok = write_e & (!full | rd_ok).
  - Simultaneous read+write while full: both accepted, count stays DEPTH.
  - Simultaneous read+write while empty: write accepted, read rejected (underflow pulse), count goes 0->1.
- Write: on wr_ok, mem[wptr] <= data_in and wptr increments.
- Read latency: on rd_ok, data_out <= mem[rptr] at that clock edge and rptr increments.
  - data_out is valid the cycle after the read is accepted.
  - Otherwise data_out holds its last value.
- Count:
  - Increments on wr_ok & !rd_ok.
  - Decrements on rd_ok & !wr_ok.
  - Unchanged otherwise.
- Flags:
  - full, empty, almost_full and almost_empty are combinational from the registered count/pointers.
  - They update the cycle after the causing edge; no glitching on requests.
- overflow <= write_e & !wr_ok; underflow <= read_e & !rd_ok.
  - Registered pulses, high for exactly the cycle after the rejected request.
  - Not sticky.
- Flush (synchronous, has priority over read/write in the same cycle):
  - Pointers = 0, count = 0, overflow = underflow = 0.
  - data_out holds its value.
  - Requests in the flush cycle are ignored and raise no error pulse.
- Elaboration checks: if DEPTH is not a power of two, or AF_TH/AE_TH are out of range, raise an elaboration error via a generate-time $error.

Test Plan:
- Reset mid-stream: write 3 words, pull reset low between clock edges -> count=0, empty=1 and data_out=0 immediately; a following read_e gives underflow=1 for one cycle.
- Fill/drain, WIDTH=8, DEPTH=8:
  - Write 0x01..0x08 -> full=1, count=8, almost_full=1 after the 7th write.
  - A 9th write (0xFF) -> overflow pulse, contents unchanged.
  - Read 8 times -> data_out = 0x01..0x08, each one cycle after its read_e; empty=1 after the last.
- Simultaneous read+write at full: with count=8, write 0xAA and read in one cycle -> count stays 8, no overflow, data_out = oldest word; 0xAA is read out last after 7 more reads.
- Simultaneous read+write at empty: with count=0, write 0x55 and read -> underflow pulse, count=1; the next read returns data_out=0x55.
- Wrap-around: 20 cycles of continuous one-in/one-out streaming with values 0..19 -> output order 0..19, no flags asserted, count constant.
- Flush: with count=5, assert flush together with write_e and read_e -> next cycle count=0, empty=1, no error pulses, data_out unchanged.

Source files
------------

// File: rtl/sfifo_param.sv
// Parameterised single-clock FIFO with wrap-bit pointers, occupancy count,
// programmable almost flags, registered error pulses and synchronous flush.
module sfifo_param #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AF_TH = DEPTH - 1,
  parameter int unsigned AE_TH = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     write_e,
  input  logic [WIDTH-1:0]         data_in,
  input  logic                     read_e,
  output logic [WIDTH-1:0]         data_out,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [AW:0]   PtrInc = {{AW{1'b0}}, 1'b1};
  localparam logic [CW-1:0] CntInc = {{AW{1'b0}}, 1'b1};
  localparam logic [CW-1:0] AfTh   = CW'(AF_TH);
  localparam logic [CW-1:0] AeTh   = CW'(AE_TH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("sfifo_param: DEPTH must be a power of two >= 2");
  end
  if (AF_TH == 0 || AF_TH > DEPTH) begin : g_bad_af
    $error("sfifo_param: AF_TH must be in 1..DEPTH");
  end
  if (AE_TH > DEPTH - 1) begin : g_bad_ae
    $error("sfifo_param: AE_TH must be in 0..DEPTH-1");
  end

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             mem_we;
  logic [AW:0]      wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic             overflow_q, overflow_d, underflow_q, underflow_d;
  logic             rd_ok, wr_ok;

  // Same slot with differing wrap bits means the writer is a full lap ahead.
  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[AW] != rptr_q[AW]);
  assign almost_full  = (count_q >= AfTh);
  assign almost_empty = (count_q <= AeTh);
  assign count     = count_q;
  assign data_out  = data_out_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

  always_comb begin
    rd_ok       = read_e & ~empty;
    wr_ok       = write_e & (~full | rd_ok);
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    count_d     = count_q;
    data_out_d  = data_out_q;
    overflow_d  = 1'b0;
    underflow_d = 1'b0;
    mem_we      = 1'b0;
    if (flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      overflow_d  = write_e & ~wr_ok;
      underflow_d = read_e & ~rd_ok;
      if (wr_ok) begin
        wptr_d = wptr_q + PtrInc;
        mem_we = 1'b1;
      end
      if (rd_ok) begin
        rptr_d     = rptr_q + PtrInc;
        data_out_d = mem_q[rptr_q[AW-1:0]];
      end
      if (wr_ok && !rd_ok) begin
        count_d = count_q + CntInc;
      end else if (rd_ok && !wr_ok) begin
        count_d = count_q - CntInc;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      data_out_q  <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      data_out_q  <= data_out_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is deliberately left unreset; the pointers alone define validity.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[wptr_q[AW-1:0]] <= data_in;
    end
  end

endmodule
